// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: constants shared by the memory responder and control unit.
// FSM encodings, RW/size request codes, wait-counter sizing helper.
package cpu_mem_pkg;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MEM_DONE = 2'd2;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU <-> memory request/complete handshake bundle.
// master = control unit (MAR/MDR side), slave = memory responder.
interface mem_responder_if;

  logic        memEnable;
  logic        RW;
  logic        isByte;
  logic        unSign;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        MOC;
  logic        addrError;

  modport master (
    output memEnable, RW, isByte, unSign, address, dataIn,
    input  dataOut, MOC, addrError
  );

  modport slave (
    input  memEnable, RW, isByte, unSign, address, dataIn,
    output dataOut, MOC, addrError
  );

endinterface

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: combinational read formatting and write lane steering.
// rword/wlanes are big-endian: [31:24] is the byte at the base address.
module mem_byte_lane
  import cpu_mem_pkg::*;
(
  input  logic        size,
  input  logic        uns,
  input  logic [1:0]  alo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] rdata,
  output logic [3:0]  we,
  output logic [31:0] wlanes,
  output logic        misal
);

  always_comb begin
    rdata  = rword;
    we     = 4'b1111;
    wlanes = wdata;
    misal  = 1'b0;
    unique case (1'b1)
      (size == SIZE_BYTE): begin
        rdata  = uns ? {24'h0, rword[31:24]}
                     : {{24{rword[31]}}, rword[31:24]};
        we     = 4'b1000;
        wlanes = {wdata[7:0], 24'h0};
      end
      default: begin
        misal = (alo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory end of the 4-phase memEnable/MOC handshake.
// clk, reset (async high), bus = slave side of mem_responder_if.
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int    ADDR_BITS   = 9,
  parameter int    WAIT_STATES = 2,
  parameter string MEM_FILE    = ""
) (
  input logic          clk,
  input logic          reset,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CW    = cnt_width(WAIT_STATES);
  localparam logic [CW-1:0] WLAST = CW'(WAIT_STATES);

  typedef logic [ADDR_BITS-1:0] addr_t;

  logic [7:0]    mem [DEPTH];
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic          q_rw;
  logic          q_size;
  logic          q_uns;
  addr_t         q_a;
  logic [31:0]   q_d;

  addr_t         base;
  logic [31:0]   rword;
  logic [31:0]   rdata;
  logic [31:0]   wlanes;
  logic [3:0]    we;
  logic          misal;
  logic          go_done;
  logic          unused_addr;

  assign unused_addr = ^bus.address[31:ADDR_BITS];

  // Word accesses ignore the low two address bits.
  assign base = (q_size == SIZE_BYTE) ? q_a
              : {q_a[ADDR_BITS-1:2], 2'b00};

  assign rword = {mem[base],
                  mem[base + addr_t'(1)],
                  mem[base + addr_t'(2)],
                  mem[base + addr_t'(3)]};

  // WAIT always lasts WAIT_STATES+1 cycles, so MOC
  // rises WAIT_STATES+1 edges after acceptance.
  assign go_done = bus.memEnable
                && (state == MEM_WAIT)
                && (cnt == WLAST);

  mem_byte_lane u_lane (
    .size   (q_size),
    .uns    (q_uns),
    .alo    (q_a[1:0]),
    .wdata  (q_d),
    .rword  (rword),
    .rdata  (rdata),
    .we     (we),
    .wlanes (wlanes),
    .misal  (misal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= MEM_IDLE;
      cnt           <= '0;
      q_rw          <= RW_READ;
      q_size        <= SIZE_WORD;
      q_uns         <= 1'b0;
      q_a           <= '0;
      q_d           <= '0;
      bus.MOC       <= 1'b0;
      bus.addrError <= 1'b0;
      bus.dataOut   <= '0;
    end else begin
      unique case (1'b1)
        (state == MEM_IDLE): begin
          if (bus.memEnable) begin
            q_rw   <= bus.RW;
            q_size <= bus.isByte;
            q_uns  <= bus.unSign;
            q_a    <= bus.address[ADDR_BITS-1:0];
            q_d    <= bus.dataIn;
            cnt    <= '0;
            state  <= MEM_WAIT;
          end
        end
        (state == MEM_WAIT): begin
          if (!bus.memEnable) begin
            state <= MEM_IDLE;
          end else if (cnt == WLAST) begin
            state <= MEM_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        (state == MEM_DONE): begin
          if (!bus.memEnable) begin
            state         <= MEM_IDLE;
            bus.MOC       <= 1'b0;
            bus.addrError <= 1'b0;
          end
        end
        default: state <= MEM_IDLE;
      endcase
      if (go_done) begin
        bus.MOC       <= 1'b1;
        bus.addrError <= misal;
        if (q_rw == RW_READ) bus.dataOut <= rdata;
      end
    end
  end

  // Storage has no reset; commit happens on the DONE entry edge.
  always_ff @(posedge clk) begin
    if (go_done && q_rw == RW_WRITE) begin
      if (we[3]) mem[base]               <= wlanes[31:24];
      if (we[2]) mem[base + addr_t'(1)]  <= wlanes[23:16];
      if (we[1]) mem[base + addr_t'(2)]  <= wlanes[15:8];
      if (we[0]) mem[base + addr_t'(3)]  <= wlanes[7:0];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder.
// dut0 uses 2 wait states, dut1 uses 0 wait states.
module tb_mem_responder;
  import cpu_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        en0, en1, rw_t, sz_t, uns_t;
  logic [31:0] a_t, d_t;

  mem_responder_if m0();
  mem_responder_if m1();

  assign m0.memEnable = en0;
  assign m0.RW        = rw_t;
  assign m0.isByte    = sz_t;
  assign m0.unSign    = uns_t;
  assign m0.address   = a_t;
  assign m0.dataIn    = d_t;
  assign m1.memEnable = en1;
  assign m1.RW        = rw_t;
  assign m1.isByte    = sz_t;
  assign m1.unSign    = uns_t;
  assign m1.address   = a_t;
  assign m1.dataIn    = d_t;

  mem_responder #(.ADDR_BITS(9), .WAIT_STATES(2), .MEM_FILE("")) dut0 (
    .clk(clk), .reset(reset), .bus(m0.slave));
  mem_responder #(.ADDR_BITS(9), .WAIT_STATES(0), .MEM_FILE("")) dut1 (
    .clk(clk), .reset(reset), .bus(m1.slave));

  int vec = 0;
  int errs = 0;

  logic [7:0]  mm [512];
  logic [31:0] exp_out;

  function automatic logic [31:0] m_read(bit sz, bit u, logic [31:0] a);
    int b;
    b = int'(a[8:0]);
    if (sz) return u ? {24'h0, mm[b]} : {{24{mm[b][7]}}, mm[b]};
    b = b - (b % 4);
    return {mm[b], mm[b+1], mm[b+2], mm[b+3]};
  endfunction

  function automatic void m_write(bit sz, logic [31:0] a, logic [31:0] d);
    int b;
    b = int'(a[8:0]);
    if (sz) begin
      mm[b] = d[7:0];
    end else begin
      b = b - (b % 4);
      mm[b] = d[31:24]; mm[b+1] = d[23:16];
      mm[b+2] = d[15:8]; mm[b+3] = d[7:0];
    end
  endfunction

  // Model update for dut0; returns expected addrError.
  function automatic bit m_apply(bit rw, bit sz, bit u, logic [31:0] a,
                                 logic [31:0] d);
    if (rw) m_write(sz, a, d);
    else exp_out = m_read(sz, u, a);
    return !sz && (a[1:0] != 2'b00);
  endfunction

  // Full 4-phase transaction; called at a negedge, returns at a negedge.
  // Request fields are scrambled after acceptance to prove latching.
  task automatic xact(input bit which, input bit rw, input bit sz, input bit u,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] dout, output logic err,
                      output int lat);
    logic moc;
    rw_t = rw; sz_t = sz; uns_t = u; a_t = a; d_t = d;
    if (which) en1 = 1'b1; else en0 = 1'b1;
    @(posedge clk);
    #1;
    rw_t = 1'($urandom); sz_t = 1'($urandom);
    a_t = $urandom; d_t = $urandom;
    lat = -1;
    dout = 'x;
    err = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      moc = which ? m1.MOC : m0.MOC;
      if (moc) begin
        lat = i;
        dout = which ? m1.dataOut : m0.dataOut;
        err = which ? m1.addrError : m0.addrError;
        break;
      end
    end
    @(negedge clk);
    en0 = 1'b0; en1 = 1'b0;
    @(posedge clk);
    #1;
    moc = which ? m1.MOC : m0.MOC;
    vec++;
    if (moc !== 1'b0) begin
      errs++;
      $display("FAIL moc_release got=%b exp=0", moc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; en0 = 0; en1 = 0;
    rw_t = 0; sz_t = 0; uns_t = 0; a_t = 0; d_t = 0;
    #1;
    vec++; if (m0.MOC !== 1'b0) begin errs++; $display("FAIL rst_moc0 got=%b exp=0", m0.MOC); end
    vec++; if (m0.addrError !== 1'b0) begin errs++; $display("FAIL rst_err0 got=%b exp=0", m0.addrError); end
    vec++; if (m0.dataOut !== 32'h0) begin errs++; $display("FAIL rst_dout0 got=%h exp=0", m0.dataOut); end
    vec++; if (m1.MOC !== 1'b0) begin errs++; $display("FAIL rst_moc1 got=%b exp=0", m1.MOC); end
    vec++; if (m1.dataOut !== 32'h0) begin errs++; $display("FAIL rst_dout1 got=%h exp=0", m1.dataOut); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_out = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    logic [31:0] d, o; logic e; int l; bit ee;
    for (int i = 0; i < 128; i++) begin
      d = $urandom;
      ee = m_apply(1, 0, 0, 32'(i * 4), d);
      xact(0, 1, 0, 0, 32'(i * 4), d, o, e, l);
      vec++; if (l !== 3) begin errs++; $display("FAIL fill_lat i=%0d got=%0d exp=3", i, l); end
    end
  endtask

  task automatic test_word();
    logic [31:0] o; logic e; int l; bit ee;
    ee = m_apply(1, 0, 0, 32'h10, 32'h12345678);
    xact(0, 1, 0, 0, 32'h10, 32'h12345678, o, e, l);
    vec++; if (l !== 3) begin errs++; $display("FAIL wr_lat got=%0d exp=3", l); end
    ee = m_apply(0, 0, 0, 32'h10, 0);
    xact(0, 0, 0, 0, 32'h10, 0, o, e, l);
    vec++; if (o !== 32'h12345678) begin errs++; $display("FAIL rd_word got=%h exp=12345678", o); end
    vec++; if (e !== 1'b0) begin errs++; $display("FAIL rd_word_err got=%b exp=0", e); end
    ee = m_apply(0, 1, 1, 32'h10, 0);
    xact(0, 0, 1, 1, 32'h10, 0, o, e, l);
    vec++; if (o !== 32'h12) begin errs++; $display("FAIL rd_b10 got=%h exp=12", o); end
    ee = m_apply(0, 1, 1, 32'h13, 0);
    xact(0, 0, 1, 1, 32'h13, 0, o, e, l);
    vec++; if (o !== 32'h78) begin errs++; $display("FAIL rd_b13 got=%h exp=78", o); end
  endtask

  task automatic test_byte_sign();
    logic [31:0] o; logic e; int l; bit ee;
    ee = m_apply(1, 1, 0, 32'h21, 32'hABCDEF80);
    xact(0, 1, 1, 0, 32'h21, 32'hABCDEF80, o, e, l);
    vec++; if (o !== exp_out) begin errs++; $display("FAIL sb_dout_hold got=%h exp=%h", o, exp_out); end
    ee = m_apply(0, 1, 0, 32'h21, 0);
    xact(0, 0, 1, 0, 32'h21, 0, o, e, l);
    vec++; if (o !== 32'hFFFFFF80) begin errs++; $display("FAIL lb got=%h exp=FFFFFF80", o); end
    ee = m_apply(0, 1, 1, 32'h21, 0);
    xact(0, 0, 1, 1, 32'h21, 0, o, e, l);
    vec++; if (o !== 32'h00000080) begin errs++; $display("FAIL lbu got=%h exp=00000080", o); end
    ee = m_apply(0, 0, 0, 32'h20, 0);
    xact(0, 0, 0, 0, 32'h20, 0, o, e, l);
    vec++; if (o !== exp_out) begin errs++; $display("FAIL lw20 got=%h exp=%h", o, exp_out); end
  endtask

  task automatic test_latency0();
    logic [31:0] o; logic e; int l;
    xact(1, 1, 0, 0, 32'h8, 32'hCAFEF00D, o, e, l);
    vec++; if (l !== 1) begin errs++; $display("FAIL ws0_wr_lat got=%0d exp=1", l); end
    xact(1, 0, 0, 0, 32'h8, 0, o, e, l);
    vec++; if (l !== 1) begin errs++; $display("FAIL ws0_rd_lat got=%0d exp=1", l); end
    vec++; if (o !== 32'hCAFEF00D) begin errs++; $display("FAIL ws0_rd got=%h exp=CAFEF00D", o); end
  endtask

  task automatic test_abort();
    logic [31:0] o; logic e; int l; bit ee; bit seen;
    rw_t = 1; sz_t = 0; uns_t = 0; a_t = 32'h30; d_t = 32'hDEADBEEF;
    en0 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    en0 = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (m0.MOC) seen = 1;
    end
    vec++; if (seen !== 1'b0) begin errs++; $display("FAIL abort_moc got=%b exp=0", seen); end
    vec++; if (m0.dataOut !== exp_out) begin errs++; $display("FAIL abort_dout got=%h exp=%h", m0.dataOut, exp_out); end
    @(negedge clk);
    ee = m_apply(0, 0, 0, 32'h30, 0);
    xact(0, 0, 0, 0, 32'h30, 0, o, e, l);
    vec++; if (o !== exp_out) begin errs++; $display("FAIL abort_old got=%h exp=%h", o, exp_out); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] o; logic e; int l; bit ee;
    rw_t = 1; sz_t = 0; uns_t = 0; a_t = 32'h40; d_t = 32'h11223344;
    en0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vec++; if (m0.MOC !== 1'b0) begin errs++; $display("FAIL rstmid_moc got=%b exp=0", m0.MOC); end
    vec++; if (m0.dataOut !== 32'h0) begin errs++; $display("FAIL rstmid_dout got=%h exp=0", m0.dataOut); end
    exp_out = 32'h0;
    en0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ee = m_apply(0, 0, 0, 32'h40, 0);
    xact(0, 0, 0, 0, 32'h40, 0, o, e, l);
    vec++; if (o !== exp_out) begin errs++; $display("FAIL rstmid_mem got=%h exp=%h", o, exp_out); end
  endtask

  task automatic test_misalign_wrap();
    logic [31:0] o; logic e; int l; bit ee;
    ee = m_apply(0, 0, 0, 32'h102, 0);
    xact(0, 0, 0, 0, 32'h102, 0, o, e, l);
    vec++; if (e !== 1'b1) begin errs++; $display("FAIL mis_rd_err got=%b exp=1", e); end
    vec++; if (o !== exp_out) begin errs++; $display("FAIL mis_rd got=%h exp=%h", o, exp_out); end
    ee = m_apply(1, 0, 0, 32'h106, 32'h0BADF00D);
    xact(0, 1, 0, 0, 32'h106, 32'h0BADF00D, o, e, l);
    vec++; if (e !== 1'b1) begin errs++; $display("FAIL mis_wr_err got=%b exp=1", e); end
    ee = m_apply(0, 0, 0, 32'h104, 0);
    xact(0, 0, 0, 0, 32'h104, 0, o, e, l);
    vec++; if (o !== 32'h0BADF00D) begin errs++; $display("FAIL mis_wr_data got=%h exp=0BADF00D", o); end
    ee = m_apply(1, 0, 0, 32'h1FC, 32'hA5A55A5A);
    xact(0, 1, 0, 0, 32'h1FC, 32'hA5A55A5A, o, e, l);
    ee = m_apply(0, 0, 0, 32'h1FC, 0);
    xact(0, 0, 0, 0, 32'h1FC, 0, o, e, l);
    vec++; if (o !== 32'hA5A55A5A) begin errs++; $display("FAIL top_word got=%h exp=A5A55A5A", o); end
    ee = m_apply(0, 0, 0, 32'h200, 0);
    xact(0, 0, 0, 0, 32'h200, 0, o, e, l);
    vec++; if (o !== exp_out) begin errs++; $display("FAIL alias200 got=%h exp=%h", o, exp_out); end
    ee = m_apply(0, 1, 1, 32'hFFFFFFFF, 0);
    xact(0, 0, 1, 1, 32'hFFFFFFFF, 0, o, e, l);
    vec++; if (o !== 32'h5A) begin errs++; $display("FAIL alias_b1ff got=%h exp=5A", o); end
  endtask

  task automatic test_hold();
    logic [31:0] o; logic e; int l; bit ee; bit drop;
    ee = m_apply(0, 0, 0, 32'h10, 0);
    rw_t = 0; sz_t = 0; uns_t = 0; a_t = 32'h10; d_t = 0;
    en0 = 1'b1;
    @(posedge clk);
    l = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (m0.MOC) begin l = i; break; end
    end
    vec++; if (l !== 3) begin errs++; $display("FAIL hold_lat got=%0d exp=3", l); end
    drop = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (!m0.MOC) drop = 1;
    end
    vec++; if (drop !== 1'b0) begin errs++; $display("FAIL hold_moc got=%b exp=0", drop); end
    vec++; if (m0.dataOut !== exp_out) begin errs++; $display("FAIL hold_dout got=%h exp=%h", m0.dataOut, exp_out); end
    @(negedge clk);
    en0 = 1'b0;
    @(posedge clk);
    #1;
    vec++; if (m0.MOC !== 1'b0) begin errs++; $display("FAIL hold_release got=%b exp=0", m0.MOC); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] o, a, d; logic e; int l; bit ee, rw, sz, u;
    for (int i = 0; i < 150; i++) begin
      rw = 1'($urandom); sz = 1'($urandom); u = 1'($urandom);
      a = $urandom; d = $urandom;
      ee = m_apply(rw, sz, u, a, d);
      xact(0, rw, sz, u, a, d, o, e, l);
      vec++; if (l !== 3) begin errs++; $display("FAIL rnd_lat i=%0d got=%0d exp=3", i, l); end
      vec++; if (o !== exp_out) begin errs++; $display("FAIL rnd_dout i=%0d a=%h got=%h exp=%h", i, a, o, exp_out); end
      vec++; if (e !== ee) begin errs++; $display("FAIL rnd_err i=%0d a=%h got=%b exp=%b", i, a, e, ee); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word();
    test_byte_sign();
    test_latency0();
    test_abort();
    test_reset_mid();
    test_misalign_wrap();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
